// File: rtl/fram_bank_mgr.sv
// Frame-bank manager: rotates the writer and reader across NUM_FRAMES DDR banks without tearing,
// and arbitrates write/read bursts round-robin onto one command port with one command outstanding.
module fram_bank_mgr #(
    parameter int unsigned          ADDR_WIDTH       = 28,
    parameter int unsigned          LEN_WIDTH        = 32,
    parameter int unsigned          FRAME_ADDR_WIDTH = 22,
    parameter int unsigned          NUM_FRAMES       = 3,
    parameter int unsigned          BANK_W           = 3,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET     = '0
) (
    input  logic                        ddr_clk,
    input  logic                        ddr_rstn,
    input  logic                        wr_frame_start,
    input  logic                        wr_frame_done,
    input  logic                        rd_frame_start,
    input  logic                        wr_req,
    input  logic [FRAME_ADDR_WIDTH-1:0] wr_offset,
    input  logic [LEN_WIDTH-1:0]        wr_len,
    output logic                        wr_ack,
    output logic                        wr_done,
    input  logic                        rd_req,
    input  logic [FRAME_ADDR_WIDTH-1:0] rd_offset,
    input  logic [LEN_WIDTH-1:0]        rd_len,
    output logic                        rd_ack,
    output logic                        rd_done,
    output logic                        cmd_en,
    output logic                        cmd_wr,
    output logic [ADDR_WIDTH-1:0]       cmd_addr,
    output logic [LEN_WIDTH-1:0]        cmd_len,
    input  logic                        cmd_ready,
    input  logic                        cmd_done,
    output logic [BANK_W-1:0]           wr_bank,
    output logic [BANK_W-1:0]           rd_bank,
    output logic                        init_done,
    output logic                        frame_irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_FRAMES - 1);

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b >= LAST_BANK) ? '0 : b + BANK_W'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] bank_addr(input logic [BANK_W-1:0]           b,
                                                        input logic [FRAME_ADDR_WIDTH-1:0] off);
        return ADDR_OFFSET + (ADDR_WIDTH'(b) << FRAME_ADDR_WIDTH) + ADDR_WIDTH'(off);
    endfunction

    state_e                  state_q, state_d;
    logic [BANK_W-1:0]       wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0]       rd_bank_q, rd_bank_d;
    logic [BANK_W-1:0]       latest_q, latest_d;
    logic                    fresh_q, fresh_d;
    logic                    init_done_q, init_done_d;
    logic                    frame_irq_q, frame_irq_d;
    logic                    last_wr_q, last_wr_d;
    logic                    gnt_wr_q, gnt_wr_d;
    logic                    cmd_en_q, cmd_en_d;
    logic                    cmd_wr_q, cmd_wr_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LEN_WIDTH-1:0]    cmd_len_q, cmd_len_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    wr_done_q, wr_done_d;
    logic                    rd_done_q, rd_done_d;

    logic                    fwd_fresh;
    logic [BANK_W-1:0]       fwd_latest;
    logic [BANK_W-1:0]       rot_bank;
    logic                    pick_wr;

    // Bank bookkeeping and arbiter next state
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        latest_d    = latest_q;
        fresh_d     = fresh_q;
        init_done_d = init_done_q;
        frame_irq_d = wr_frame_done;
        last_wr_d   = last_wr_q;
        gnt_wr_d    = gnt_wr_q;
        cmd_en_d    = cmd_en_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        pick_wr     = 1'b0;

        // A frame finishing in the same cycle the reader starts is handed straight to the reader
        fwd_fresh  = fresh_q | wr_frame_done;
        fwd_latest = wr_frame_done ? wr_bank_q : latest_q;

        if (wr_frame_done) begin
            latest_d    = wr_bank_q;
            fresh_d     = 1'b1;
            init_done_d = 1'b1;
        end

        if (rd_frame_start && fwd_fresh) begin
            rd_bank_d = fwd_latest;
            fresh_d   = 1'b0;
        end

        // Rotation sees the reader's updated bank so the writer never lands on it
        rot_bank = bank_inc(wr_bank_q);
        if (rot_bank == rd_bank_d) begin
            rot_bank = bank_inc(rot_bank);
        end
        if (wr_frame_start) begin
            wr_bank_d = rot_bank;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_req || rd_req) begin
                    pick_wr    = wr_req && (!rd_req || !last_wr_q);
                    gnt_wr_d   = pick_wr;
                    cmd_en_d   = 1'b1;
                    cmd_wr_d   = pick_wr;
                    cmd_addr_d = pick_wr ? bank_addr(wr_bank_q, wr_offset)
                                         : bank_addr(rd_bank_q, rd_offset);
                    cmd_len_d  = pick_wr ? wr_len : rd_len;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_en_d = 1'b0;
                    wr_ack_d = gnt_wr_q;
                    rd_ack_d = !gnt_wr_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    wr_done_d = gnt_wr_q;
                    rd_done_d = !gnt_wr_q;
                    last_wr_d = gnt_wr_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            latest_q    <= '0;
            fresh_q     <= 1'b0;
            init_done_q <= 1'b0;
            frame_irq_q <= 1'b0;
            last_wr_q   <= 1'b0;
            gnt_wr_q    <= 1'b0;
            cmd_en_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            latest_q    <= latest_d;
            fresh_q     <= fresh_d;
            init_done_q <= init_done_d;
            frame_irq_q <= frame_irq_d;
            last_wr_q   <= last_wr_d;
            gnt_wr_q    <= gnt_wr_d;
            cmd_en_q    <= cmd_en_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign init_done = init_done_q;
    assign frame_irq = frame_irq_q;
    assign cmd_en    = cmd_en_q;
    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_fram_bank_mgr.sv
// Bench for fram_bank_mgr: a 3-bank instance with full arbitration and a 2-bank instance for rotation,
// both checked every cycle against an event-level model plus hand-computed literals.
module tb_fram_bank_mgr;

    localparam int unsigned AW = 28;
    localparam int unsigned LW = 32;
    localparam int unsigned FW = 22;

    logic          ddr_clk = 1'b0;
    logic          ddr_rstn = 1'b0;
    logic          wr_frame_start, wr_frame_done, rd_frame_start;
    logic          wr_req, rd_req, cmd_ready, cmd_done;
    logic [FW-1:0] wr_offset, rd_offset;
    logic [LW-1:0] wr_len, rd_len;
    logic          wr_ack, wr_done, rd_ack, rd_done, cmd_en, cmd_wr, init_done, frame_irq;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [2:0]    wr_bank, rd_bank;

    logic          f2_wfs, f2_wfd, f2_rfs;
    logic          u1_wr_ack, u1_wr_done, u1_rd_ack, u1_rd_done, u1_cmd_en, u1_cmd_wr;
    logic          u1_init_done, u1_frame_irq;
    logic [AW-1:0] u1_cmd_addr;
    logic [LW-1:0] u1_cmd_len;
    logic [0:0]    u1_wr_bank, u1_rd_bank;

    int n_checks = 0;
    int n_err    = 0;

    always #5 ddr_clk = ~ddr_clk;

    fram_bank_mgr u0 (
        .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn),
        .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
        .wr_req(wr_req), .wr_offset(wr_offset), .wr_len(wr_len), .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_offset(rd_offset), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
        .cmd_en(cmd_en), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .init_done(init_done), .frame_irq(frame_irq)
    );

    fram_bank_mgr #(.NUM_FRAMES(2), .BANK_W(1)) u1 (
        .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn),
        .wr_frame_start(f2_wfs), .wr_frame_done(f2_wfd), .rd_frame_start(f2_rfs),
        .wr_req(1'b0), .wr_offset('0), .wr_len('0), .wr_ack(u1_wr_ack), .wr_done(u1_wr_done),
        .rd_req(1'b0), .rd_offset('0), .rd_len('0), .rd_ack(u1_rd_ack), .rd_done(u1_rd_done),
        .cmd_en(u1_cmd_en), .cmd_wr(u1_cmd_wr), .cmd_addr(u1_cmd_addr), .cmd_len(u1_cmd_len),
        .cmd_ready(1'b0), .cmd_done(1'b0),
        .wr_bank(u1_wr_bank), .rd_bank(u1_rd_bank), .init_done(u1_init_done), .frame_irq(u1_frame_irq)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- event-level model ----------------
    int      mw[2], mr[2], ml[2];
    bit      mf[2], mi[2], mirq[2];
    int      nf[2] = '{3, 2};
    bit      e_en, e_wr, e_wack, e_rack, e_wdone, e_rdone;
    longint  e_addr, e_len;
    bit      m_busy, m_side, m_lastwr;

    function automatic int next_wr(input int w, input int r, input int n);
        int c;
        c = (w + 1) % n;
        if (c == r) c = (c + 1) % n;
        return c;
    endfunction

    function automatic longint addr_of(input int bank, input longint off);
        return ((longint'(bank) << FW) + off) & ((64'd1 << AW) - 1);
    endfunction

    always @(posedge ddr_clk or negedge ddr_rstn) begin : model
        bit ws[2], wd[2], rs[2];
        bit was_en, was_busy;
        if (!ddr_rstn) begin
            for (int i = 0; i < 2; i++) begin
                mw[i] = 0; mr[i] = 0; ml[i] = 0; mf[i] = 0; mi[i] = 0; mirq[i] = 0;
            end
            e_en = 0; e_wr = 0; e_addr = 0; e_len = 0;
            e_wack = 0; e_rack = 0; e_wdone = 0; e_rdone = 0;
            m_busy = 0; m_side = 0; m_lastwr = 0;
        end else begin
            ws[0] = wr_frame_start; wd[0] = wr_frame_done; rs[0] = rd_frame_start;
            ws[1] = f2_wfs;         wd[1] = f2_wfd;        rs[1] = f2_rfs;
            e_wack = 0; e_rack = 0; e_wdone = 0; e_rdone = 0;
            was_en   = e_en;
            was_busy = m_busy;
            if (!was_en && !was_busy && (wr_req || rd_req)) begin
                m_side = wr_req && !(rd_req && m_lastwr);
                e_en   = 1;
                e_wr   = m_side;
                e_addr = m_side ? addr_of(mw[0], longint'(wr_offset)) : addr_of(mr[0], longint'(rd_offset));
                e_len  = m_side ? longint'(wr_len) : longint'(rd_len);
            end else if (was_en && cmd_ready) begin
                e_en   = 0;
                m_busy = 1;
                e_wack = m_side;
                e_rack = !m_side;
            end else if (was_busy && cmd_done) begin
                m_busy   = 0;
                e_wdone  = m_side;
                e_rdone  = !m_side;
                m_lastwr = m_side;
            end
            for (int i = 0; i < 2; i++) begin
                mirq[i] = wd[i];
                if (wd[i]) begin
                    ml[i] = mw[i]; mf[i] = 1; mi[i] = 1;
                end
                if (rs[i] && mf[i]) begin
                    mr[i] = ml[i]; mf[i] = 0;
                end
                if (ws[i]) mw[i] = next_wr(mw[i], mr[i], nf[i]);
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge ddr_clk);
            chk("wr_bank",   64'(wr_bank),   64'(mw[0]));
            chk("rd_bank",   64'(rd_bank),   64'(mr[0]));
            chk("init_done", 64'(init_done), 64'(mi[0]));
            chk("frame_irq", 64'(frame_irq), 64'(mirq[0]));
            chk("cmd_en",    64'(cmd_en),    64'(e_en));
            chk("cmd_wr",    64'(cmd_wr),    64'(e_wr));
            chk("cmd_addr",  64'(cmd_addr),  64'(e_addr));
            chk("cmd_len",   64'(cmd_len),   64'(e_len));
            chk("wr_ack",    64'(wr_ack),    64'(e_wack));
            chk("rd_ack",    64'(rd_ack),    64'(e_rack));
            chk("wr_done",   64'(wr_done),   64'(e_wdone));
            chk("rd_done",   64'(rd_done),   64'(e_rdone));
            chk("n2_wr_bank",   64'(u1_wr_bank),   64'(mw[1]));
            chk("n2_rd_bank",   64'(u1_rd_bank),   64'(mr[1]));
            chk("n2_init_done", 64'(u1_init_done), 64'(mi[1]));
            chk("n2_frame_irq", 64'(u1_frame_irq), 64'(mirq[1]));
            chk("n2_cmd_en",    64'(u1_cmd_en),    64'd0);
        end
    end

    // Simple controller: cmd_done two cycles after each accept
    bit auto_done = 0;
    int done_cnt  = 0;
    initial begin
        forever begin
            @(negedge ddr_clk);
            if (auto_done) begin
                cmd_done = 1'b0;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) cmd_done = 1'b1;
                end
                if (cmd_en && cmd_ready) done_cnt = 2;
            end
        end
    end

    bit              log_en = 0;
    bit              q_wr[$];
    logic [AW-1:0]   q_addr[$];
    initial begin
        forever begin
            @(negedge ddr_clk);
            if (log_en && cmd_en && cmd_ready) begin
                q_wr.push_back(cmd_wr);
                q_addr.push_back(cmd_addr);
            end
        end
    end

    task automatic do_reset();
        ddr_rstn = 1'b0;
        {wr_frame_start, wr_frame_done, rd_frame_start, f2_wfs, f2_wfd, f2_rfs} = '0;
        wr_req = 0; rd_req = 0; cmd_ready = 0; cmd_done = 0;
        wr_offset = '0; rd_offset = '0; wr_len = '0; rd_len = '0;
        done_cnt = 0;
        repeat (2) @(negedge ddr_clk);
        ddr_rstn = 1'b1;
    endtask

    // mask = {wfs, wfd, rfs} for the 3-bank unit, then the same for the 2-bank unit
    task automatic pulse(input logic [5:0] m);
        {wr_frame_start, wr_frame_done, rd_frame_start, f2_wfs, f2_wfd, f2_rfs} = m;
        @(negedge ddr_clk);
        {wr_frame_start, wr_frame_done, rd_frame_start, f2_wfs, f2_wfd, f2_rfs} = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        do_reset();
        @(negedge ddr_clk);
        chk("rst_wr_bank", 64'(wr_bank), 64'd0);
        chk("rst_cmd_en", 64'(cmd_en), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);

        // Three frames written, reader idle on bank 0
        pulse(6'b100_000);
        chk("f1_wr_bank", 64'(wr_bank), 64'd1);
        chk("f1_init_before_done", 64'(init_done), 64'd0);
        pulse(6'b010_000);
        chk("f1_init_done", 64'(init_done), 64'd1);
        chk("f1_irq", 64'(frame_irq), 64'd1);
        @(negedge ddr_clk);
        chk("f1_irq_end", 64'(frame_irq), 64'd0);
        pulse(6'b100_000);
        chk("f2_wr_bank", 64'(wr_bank), 64'd2);
        pulse(6'b010_000);
        pulse(6'b100_000);
        chk("f3_skip_rd_bank0", 64'(wr_bank), 64'd1);

        // Reader holding bank 1, writer on bank 0 (both bank counts)
        do_reset();
        pulse(6'b100_100);
        pulse(6'b010_010);
        pulse(6'b001_001);
        chk("n3_rd_bank1", 64'(rd_bank), 64'd1);
        pulse(6'b100_100);
        pulse(6'b010_000);
        pulse(6'b100_000);
        chk("n3_wr_bank0", 64'(wr_bank), 64'd0);
        chk("n2_wr_bank0", 64'(u1_wr_bank), 64'd0);
        chk("n2_rd_bank1", 64'(u1_rd_bank), 64'd1);
        pulse(6'b100_100);
        chk("n3_skip_to_2", 64'(wr_bank), 64'd2);
        chk("n2_stays_0", 64'(u1_wr_bank), 64'd0);

        // Done and reader start together: forwarded frame
        pulse(6'b011_000);
        chk("fwd_rd_bank2", 64'(rd_bank), 64'd2);
        pulse(6'b100_000);
        chk("wr_after_fwd", 64'(wr_bank), 64'd0);
        pulse(6'b001_000);
        chk("repeat_rd_bank2", 64'(rd_bank), 64'd2);
        pulse(6'b111_000);
        chk("all3_rd_old_wr", 64'(rd_bank), 64'd0);
        chk("all3_wr_rot", 64'(wr_bank), 64'd1);

        // Round-robin with both requests held
        do_reset();
        pulse(6'b100_000);
        wr_offset = FW'(32'h100); wr_len = 32'd64;
        rd_offset = FW'(32'h20);  rd_len = 32'd16;
        q_wr.delete(); q_addr.delete();
        auto_done = 1; log_en = 1; cmd_ready = 1;
        wr_req = 1; rd_req = 1;
        waited = 0;
        while (q_wr.size() < 4 && waited < 80) begin
            @(negedge ddr_clk);
            waited++;
        end
        wr_req = 0; rd_req = 0;
        chk("arb_grants_seen", 64'(q_wr.size() >= 4), 64'd1);
        repeat (10) @(negedge ddr_clk);
        log_en = 0; auto_done = 0; cmd_done = 0;
        if (q_wr.size() >= 4) begin
            chk("grant0_W", 64'(q_wr[0]), 64'd1);
            chk("grant1_R", 64'(q_wr[1]), 64'd0);
            chk("grant2_W", 64'(q_wr[2]), 64'd1);
            chk("grant3_R", 64'(q_wr[3]), 64'd0);
            chk("wr_addr_bank1", 64'(q_addr[0]), 64'h0400100);
            chk("rd_addr_bank0", 64'(q_addr[1]), 64'h0000020);
        end

        // Stalled controller while the writer rotates
        do_reset();
        wr_offset = FW'(32'h200); wr_len = 32'd8; wr_req = 1;
        @(negedge ddr_clk);
        chk("stall_en", 64'(cmd_en), 64'd1);
        for (int i = 0; i < 5; i++) begin
            wr_frame_start = (i == 1);
            @(negedge ddr_clk);
            wr_frame_start = 0;
            chk("stall_hold_en", 64'(cmd_en), 64'd1);
            chk("stall_hold_addr", 64'(cmd_addr), 64'h0000200);
            chk("stall_hold_len", 64'(cmd_len), 64'd8);
        end
        chk("stall_wr_bank_moved", 64'(wr_bank), 64'd1);
        cmd_ready = 1;
        @(negedge ddr_clk);
        chk("stall_ack", 64'(wr_ack), 64'd1);
        chk("stall_en_drop", 64'(cmd_en), 64'd0);
        wr_req = 0; cmd_ready = 0;
        @(negedge ddr_clk);
        @(posedge ddr_clk);
        #2 ddr_rstn = 1'b0;
        #1;
        chk("arst_cmd_en", 64'(cmd_en), 64'd0);
        chk("arst_cmd_wr", 64'(cmd_wr), 64'd0);
        chk("arst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("arst_cmd_len", 64'(cmd_len), 64'd0);
        chk("arst_wr_bank", 64'(wr_bank), 64'd0);
        @(negedge ddr_clk);
        ddr_rstn = 1'b1;
        cmd_done = 1;
        @(negedge ddr_clk);
        cmd_done = 0;
        chk("stray_done_ignored", 64'(wr_done | rd_done), 64'd0);
        rd_offset = FW'(32'h30); rd_len = 32'd4; rd_req = 1;
        @(negedge ddr_clk);
        chk("idle_after_rst_en", 64'(cmd_en), 64'd1);
        chk("idle_after_rst_addr", 64'(cmd_addr), 64'h0000030);
        cmd_ready = 1;
        @(negedge ddr_clk);
        chk("rd_ack", 64'(rd_ack), 64'd1);
        rd_req = 0; cmd_ready = 0; cmd_done = 1;
        @(negedge ddr_clk);
        cmd_done = 0;
        chk("rd_done", 64'(rd_done), 64'd1);
        repeat (3) @(negedge ddr_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
